// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises rx, deframes LSB-first frames and hands each
// byte downstream over a valid/ready handshake with framing-error and overrun flags.
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [CW-1:0]         sample_cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;

    // Two-flop synchroniser; preset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking here so rx_s takes the old rx_meta, giving a true two-stage delay.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            // NOTE: the shift register is reset as well; it is small, and a defined value keeps data_out X-free.
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Accepted transfer; a frame completing below in the same cycle overrides these.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            if (!ena) begin
                state      <= IDLE;
                sample_cnt <= '0;
                bit_idx    <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state      <= START;
                            sample_cnt <= '0;
                            busy       <= 1'b1;
                        end
                    end

                    START: begin
                        if (sample_cnt == HALF_LAST) begin
                            sample_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt         <= '0;
                            shift_reg[bit_idx] <= rx_s;
                            if (bit_idx == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            bit_idx    <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (!data_valid || data_ready) begin
                                    data_out   <= shift_reg;
                                    data_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end

                    // A held-low line (break) must return high before a new start bit is accepted.
                    WAIT_IDLE: begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
